redirect_ctrl: RTL and testbench
================================

// Module: redirect_ctrl
// PURPOSE
// - Sequences control-flow redirects for the 7-stage pipeline: arbitrates exe-stage jump/taken-branch vs. late-stage trap redirect.
// - Drives the fetch PC load through a valid/ready handshake and holds per-stage flush lines until wrong-path slots have drained.
// - Sits beside stage3_top (branch source) and stage1 fetch (PC consumer); trap source is the commit-side stage.
// PARAMETERS
// - NUM_STAGES    7  pipeline depth; width of flush
// - BR_STAGE      3  stage resolving jumps/branches; flushes stages 1..BR_STAGE-1
// - TRAP_STAGE    6  stage raising traps; flushes stages 1..TRAP_STAGE inclusive
// - FLUSH_CYCLES  2  cycles flush stays high after fetch accepts the new PC (1..15)
// PORTS
// - clock          in   1           single clock; all state updates on posedge
// - reset          in   1           synchronous, active-low; sampled on posedge clock
// - exe_valid      in   1           stage 3 holds a valid instruction this cycle (is_exe_stage)
// - br_req         in   1           stage 3 jump or taken branch
// - br_target      in   word        stage 3 redirect address
// - trap_req       in   1           trap/exception redirect from TRAP_STAGE
// - trap_target    in   word        trap vector address
// - fetch_ready    in   1           fetch accepts pc_target this cycle
// - pc_load        out  1           redirect valid to fetch
// - pc_target      out  word        redirect address, stable while pc_load high
// - flush          out  NUM_STAGES  bit i squashes stage i+1
// - busy           out  1           redirect in progress (state != RUN)
// - redirect_cnt   out  16          accepted redirects, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=RUN; pc_load=0, pc_target=0, flush=0, busy=0, redirect_cnt=0, counter=0.
//   Reset mid-redirect abandons it outright; no pulse is completed.
// - All outputs registered; request seen at edge N -> pc_load/flush/busy high from cycle N+1.
// - Masks: BR_MASK = bits [BR_STAGE-2:0]; TRAP_MASK = bits [TRAP_STAGE-1:0]; all other bits 0.
// - States: RUN, REDIRECT, FLUSH.
// - RUN: trap_req -> latch trap_target, flush=TRAP_MASK, REDIRECT.
//   Else br_req & exe_valid -> latch br_target, flush=BR_MASK, REDIRECT.
//   br_req with exe_valid=0 is ignored. Both requests together: trap wins, branch dropped.
// - REDIRECT: pc_load=1; pc_target and flush held constant.
//   fetch_ready=1 -> handshake completes; counter=FLUSH_CYCLES; redirect_cnt++ (saturating); FLUSH.
//   fetch_ready=0 -> stay; no timeout.
// - FLUSH: pc_load=0; flush held. Counter decrements each cycle; at counter==1 and no preemption -> RUN, flush=0 on entry.
// - Preemption: trap_req in REDIRECT or FLUSH reloads trap_target, flush=TRAP_MASK, enters/stays in REDIRECT, counter cleared.
//   Applies even with fetch_ready=1 that cycle: the old handshake still counts (redirect_cnt++) and the new target is presented next cycle.
// - br_req outside RUN is ignored: it is wrong-path and already squashed.
// - Back-to-back: a request seen on the RUN-entry cycle is accepted; RUN lasts >=1 cycle between redirects.
// - Addresses pass through unmodified; no alignment check here (stage 1 owns misaligned fetch).
// STRUCTURE
// - Shared definitions.vh gains: word (exists), redirect state enum, FLUSH_CNT_W=4.
//   Mask helper functions br_mask/trap_mask go in the same include.
// - One sub-module: redirect_flush_timer (loadable down-counter, done flag). All else is flat FSM + output registers.
// TESTING
// - Reset: hold reset=0 3 cycles mid-REDIRECT -> all outputs 0, state RUN, redirect_cnt=0.
// - Branch: exe_valid=1, br_req=1, br_target=32'h0000_0100, fetch_ready=1 -> next cycle pc_load=1, pc_target=0x100, flush=7'b0000011.
//   Then flush high 2 more cycles; busy low on cycle 4.
// - Stall: branch to 0x200 with fetch_ready=0 for 5 cycles -> pc_load/pc_target/flush stable 5 cycles.
//   Single-cycle handshake on fetch_ready=1; redirect_cnt=1.
// - Collision: trap_req (0x8000_0000) with br_req (0x100) in RUN -> pc_target=0x8000_0000, flush=7'b0111111.
// - Preempt: branch accepted, trap_req on first FLUSH cycle -> re-enters REDIRECT with trap target, flush=TRAP_MASK, counter restarted.
// - Ignore/saturate: br_req with exe_valid=0 -> no pulse; br_req during FLUSH -> no effect.
//   Preload redirect_cnt=16'hFFFF via force, complete one redirect -> count stays 16'hFFFF.

Source files
------------

// File: rtl/redirect_ctrl_pkg.sv
// Shared definitions for the redirect controller: address word, FSM state
// encoding, flush-timer width and the stage-mask helpers.
package redirect_ctrl_pkg;

    localparam int WORD_W      = 32;
    localparam int FLUSH_CNT_W = 4;
    // Upper bound on pipeline depth that the mask helpers can describe.
    localparam int MAX_STAGES  = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } redirect_state_e;

    // Stages 1..br_stage-1 are younger than the resolving stage: bits [br_stage-2:0].
    function automatic logic [MAX_STAGES-1:0] br_mask(input int br_stage);
        logic [MAX_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < br_stage - 1) m[i] = 1'b1;
        end
        return m;
    endfunction

    // A trap squashes its own stage too: bits [trap_stage-1:0].
    function automatic logic [MAX_STAGES-1:0] trap_mask(input int trap_stage);
        logic [MAX_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < trap_stage) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/redirect_ctrl_flush_timer.sv
// Loadable down-counter that measures how long flush stays asserted after
// fetch accepts a redirect. done_o marks the last flush cycle.
module redirect_flush_timer
    import redirect_ctrl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [FLUSH_CNT_W-1:0] load_val_i,
    output logic                   done_o
);

    logic [FLUSH_CNT_W-1:0] cnt_q;
    logic [FLUSH_CNT_W-1:0] cnt_d;

    // Next count: clear beats load, otherwise free-run down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == FLUSH_CNT_W'(1));

endmodule

// File: rtl/redirect_ctrl.sv
// Control-flow redirect sequencer: arbitrates exe-stage branch redirects
// against late-stage traps, presents the new PC to fetch over a valid/ready
// handshake and holds per-stage flush until wrong-path slots have drained.
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 7,
    parameter int BR_STAGE     = 3,
    parameter int TRAP_STAGE   = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exe_valid,
    input  logic                  br_req,
    input  word_t                 br_target,
    input  logic                  trap_req,
    input  word_t                 trap_target,
    input  logic                  fetch_ready,
    output logic                  pc_load,
    output word_t                 pc_target,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  busy,
    output logic [15:0]           redirect_cnt
);

    localparam logic [MAX_STAGES-1:0]  BR_MASK_FULL   = br_mask(BR_STAGE);
    localparam logic [MAX_STAGES-1:0]  TRAP_MASK_FULL = trap_mask(TRAP_STAGE);
    localparam logic [NUM_STAGES-1:0]  BR_MASK        = BR_MASK_FULL[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0]  TRAP_MASK      = TRAP_MASK_FULL[NUM_STAGES-1:0];
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD     = FLUSH_CNT_W'(FLUSH_CYCLES);

    redirect_state_e       state_q, state_d;
    word_t                 target_q, target_d;
    logic [NUM_STAGES-1:0] flush_q, flush_d;
    logic [15:0]           redirect_cnt_q, redirect_cnt_d;

    logic tmr_load;
    logic tmr_clear;
    logic tmr_done;

    redirect_flush_timer u_flush_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .clear_i    (tmr_clear),
        .load_val_i (FLUSH_LOAD),
        .done_o     (tmr_done)
    );

    // Next-state, latched target/mask, handshake count and timer control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        target_d       = target_q;
        flush_d        = flush_q;
        redirect_cnt_d = redirect_cnt_q;
        tmr_load       = 1'b0;
        tmr_clear      = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // Trap wins a collision; a branch without a valid exe slot is a bubble.
                if (trap_req) begin
                    state_d  = ST_REDIRECT;
                    target_d = trap_target;
                    flush_d  = TRAP_MASK;
                end else if (br_req && exe_valid) begin
                    state_d  = ST_REDIRECT;
                    target_d = br_target;
                    flush_d  = BR_MASK;
                end
            end

            ST_REDIRECT: begin
                // A completed handshake counts even if a trap replaces it this cycle.
                if (fetch_ready && redirect_cnt_q != 16'hFFFF) begin
                    redirect_cnt_d = redirect_cnt_q + 16'd1;
                end
                if (trap_req) begin
                    target_d  = trap_target;
                    flush_d   = TRAP_MASK;
                    tmr_clear = 1'b1;
                end else if (fetch_ready) begin
                    state_d  = ST_FLUSH;
                    tmr_load = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Branch requests here come from already-squashed slots and are ignored.
                if (trap_req) begin
                    state_d   = ST_REDIRECT;
                    target_d  = trap_target;
                    flush_d   = TRAP_MASK;
                    tmr_clear = 1'b1;
                end else if (tmr_done) begin
                    state_d = ST_RUN;
                    flush_d = '0;
                end
            end

            default: begin
                state_d = ST_RUN;
                flush_d = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any redirect in flight.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q        <= ST_RUN;
            target_q       <= '0;
            flush_q        <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            flush_q        <= flush_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign pc_load      = (state_q == ST_REDIRECT);
    assign busy         = (state_q != ST_RUN);
    assign pc_target    = target_q;
    assign flush        = flush_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_redirect_ctrl;
    import redirect_ctrl_pkg::*;

    localparam int NS  = 7;
    localparam int BRS = 3;
    localparam int TRS = 6;
    localparam int FC  = 2;
    localparam logic [NS-1:0] BR_M   = NS'((1 << (BRS - 1)) - 1);
    localparam logic [NS-1:0] TRAP_M = NS'((1 << TRS) - 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          exe_valid = 1'b0, br_req = 1'b0, trap_req = 1'b0, fetch_ready = 1'b0;
    word_t         br_target = '0, trap_target = '0;
    logic          pc_load;
    word_t         pc_target;
    logic [NS-1:0] flush;
    logic          busy;
    logic [15:0]   redirect_cnt;

    redirect_ctrl #(
        .NUM_STAGES   (NS),
        .BR_STAGE     (BRS),
        .TRAP_STAGE   (TRS),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .exe_valid    (exe_valid),
        .br_req       (br_req),
        .br_target    (br_target),
        .trap_req     (trap_req),
        .trap_target  (trap_target),
        .fetch_ready  (fetch_ready),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .flush        (flush),
        .busy         (busy),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        word_t         target;
        logic [NS-1:0] mask;
    } redir_t;

    redir_t exp_q[$];

    // Reference model: a redirect is either being offered to fetch, or its
    // flush window is draining (cycles left), or nothing is happening.
    bit            m_offering = 0;
    int            m_drain_left = 0;
    word_t         m_target = '0;
    logic [NS-1:0] m_mask = '0;
    int unsigned   m_accepted = 0;

    // Expected outputs for the current cycle.
    logic          e_pc_load, e_busy;
    logic [NS-1:0] e_flush;
    logic [15:0]   e_cnt;
    word_t         e_target;
    bit            checking = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void start_redirect(input word_t tgt, input logic [NS-1:0] mask);
        m_offering   = 1;
        m_drain_left = 0;
        m_target     = tgt;
        m_mask       = mask;
    endfunction

    // Advance the model across the coming clock edge using the driven inputs.
    function automatic void model_step();
        if (!reset) begin
            m_offering   = 0;
            m_drain_left = 0;
            m_target     = '0;
            m_mask       = '0;
            m_accepted   = 0;
        end else if (m_offering) begin
            if (fetch_ready) begin
                exp_q.push_back(redir_t'{target: m_target, mask: m_mask});
                if (m_accepted < 65535) m_accepted++;
            end
            if (trap_req) begin
                start_redirect(trap_target, TRAP_M);
            end else if (fetch_ready) begin
                m_offering   = 0;
                m_drain_left = FC;
            end
        end else if (m_drain_left > 0) begin
            if (trap_req) begin
                start_redirect(trap_target, TRAP_M);
            end else begin
                m_drain_left--;
                if (m_drain_left == 0) m_mask = '0;
            end
        end else if (trap_req) begin
            start_redirect(trap_target, TRAP_M);
        end else if (br_req && exe_valid) begin
            start_redirect(br_target, BR_M);
        end
    endfunction

    // Drive one cycle of inputs just after the edge and step the model.
    task automatic cyc(input logic r, input logic e, input logic b, input word_t bt,
                       input logic t, input word_t tt, input logic f);
        @(posedge clock);
        #2;
        e_pc_load = m_offering;
        e_busy    = m_offering || (m_drain_left > 0);
        e_flush   = m_mask;
        e_cnt     = 16'(m_accepted);
        e_target  = m_target;
        reset       = r;
        exe_valid   = e;
        br_req      = b;
        br_target   = bt;
        trap_req    = t;
        trap_target = tt;
        fetch_ready = f;
        model_step();
        checking = 1;
    endtask

    task automatic idle(input logic f);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, f);
    endtask

    // Monitor: per-cycle output check plus handshake scoreboard.
    initial begin
        redir_t r;
        forever begin
            @(negedge clock);
            if (checking) begin
                check("pc_load", 32'(pc_load), 32'(e_pc_load));
                check("busy", 32'(busy), 32'(e_busy));
                check("flush", 32'(flush), 32'(e_flush));
                check("redirect_cnt", 32'(redirect_cnt), 32'(e_cnt));
                if (e_pc_load) check("pc_target", pc_target, e_target);
                if (pc_load && fetch_ready && reset) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL handshake: got target %h with none expected at %0t", pc_target, $time);
                    end else begin
                        r = exp_q.pop_front();
                        check("hs_target", pc_target, r.target);
                        check("hs_flush", 32'(flush), 32'(r.mask));
                    end
                end
            end
        end
    end

    initial begin
        // Power-on reset.
        repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) idle(1'b0);

        // Branch with immediate acceptance.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, '0, 1'b1);
        idle(1'b1);
        @(negedge clock);
        check("br_pc_load", 32'(pc_load), 32'd1);
        check("br_target", pc_target, 32'h0000_0100);
        check("br_flush", 32'(flush), 32'b0000011);
        idle(1'b0);
        @(negedge clock);
        check("br_flush_c2", 32'(flush), 32'b0000011);
        idle(1'b0);
        @(negedge clock);
        check("br_flush_c3", 32'(flush), 32'b0000011);
        idle(1'b0);
        @(negedge clock);
        check("br_busy_c4", 32'(busy), 32'd0);

        // Stalled fetch.
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            @(negedge clock);
            check("stall_pc_load", 32'(pc_load), 32'd1);
            check("stall_target", pc_target, 32'h0000_0200);
            check("stall_flush", 32'(flush), 32'b0000011);
        end
        idle(1'b1);
        idle(1'b0);
        @(negedge clock);
        check("stall_single_hs", 32'(pc_load), 32'd0);
        check("stall_cnt", 32'(redirect_cnt), 32'd1);
        repeat (3) idle(1'b0);

        // Trap and branch together: trap wins.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h8000_0000, 1'b0);
        idle(1'b0);
        @(negedge clock);
        check("coll_target", pc_target, 32'h8000_0000);
        check("coll_flush", 32'(flush), 32'b0111111);
        idle(1'b1);
        repeat (3) idle(1'b0);

        // Trap preempts the first flush cycle of a branch.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0, '0, 1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h0000_9000, 1'b0);
        idle(1'b0);
        @(negedge clock);
        check("pre_pc_load", 32'(pc_load), 32'd1);
        check("pre_target", pc_target, 32'h0000_9000);
        check("pre_flush", 32'(flush), 32'(TRAP_M));
        idle(1'b1);
        repeat (4) idle(1'b0);

        // Branch without a valid exe slot, and branch during flush.
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b0, '0, 1'b1);
        idle(1'b1);
        @(negedge clock);
        check("nv_no_pulse", 32'(pc_load), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, '0, 1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0600, 1'b0, '0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clock);
        check("flush_br_ignored", 32'(busy), 32'd0);

        // Reset held mid-redirect.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0700, 1'b0, '0, 1'b0);
        idle(1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b1, 32'h0000_0900, 1'b1);
        idle(1'b0);
        @(negedge clock);
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_pc_target", pc_target, 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(redirect_cnt), 32'd0);

        // Saturating redirect count.
        idle(1'b0);
        @(negedge clock);
        #1;
        force dut.redirect_cnt_q = 16'hFFFF;
        #1;
        release dut.redirect_cnt_q;
        m_accepted = 65535;
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0A00, 1'b0, '0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        @(negedge clock);
        check("sat_cnt", 32'(redirect_cnt), 32'h0000_FFFF);
        repeat (3) idle(1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(99) != 0),
                logic'($urandom_range(9) < 7),
                logic'($urandom_range(9) < 3),
                word_t'($urandom),
                logic'($urandom_range(99) < 8),
                word_t'($urandom),
                logic'($urandom_range(1)));
        end

        // Drain and confirm every predicted handshake was observed.
        repeat (8) idle(1'b1);
        @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
